multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multicycle control FSM that sequences the RV32I datapath: decodes `op_code`/`funct3`/`funct7`, steps each instruction through fetch, decode, execute, memory and writeback states, and drives every datapath select and write enable. It sits beside the datapath in the top level. It adds configurable wait states for the synchronous instruction and data memories, a retire pulse and an illegal-instruction trap.

## Interface
- `IMEM_WAIT`, 1: extra FETCH cycles before `IR_write`; covers synchronous instruction-memory read latency.
- `DMEM_WAIT`, 1: extra MEMREAD cycles so the registered `dmem_data` is valid in MEMWB.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low; sampled on `clk` rising edge.
- `op_code`  in  7  instruction [6:0].
- `funct3`  in  3  instruction [14:12].
- `funct7`  in  7  instruction [31:25]; only bit 5 is used.
- `Zero`  in  1  ALU zero flag, combinational from the current cycle.
- `adr_src`  out  1  memory address select: 0 = PC, 1 = result.
- `mem_write`  out  1  data memory write enable.
- `IR_write`  out  1  instruction and old-PC register enable.
- `reg_write`  out  1  register file write enable.
- `PC_write`  out  1  PC enable; the OR of an unconditional update and a taken branch.
- `result_src`  out  2  result select: 0 = ALU_out, 1 = dmem_data, 2 = ALU_result.
- `alu_src_a`  out  2  SrcA select: 0 = PC, 1 = old_PC, 2 = rs1 register.
- `alu_src_b`  out  2  SrcB select: 0 = rs2 register, 1 = immediate, 2 = constant 4.
- `imm_src`  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U.
- `alu_control`  out  4  ALU operation: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU, 1010 PASSB.
- `retired`  out  1  one-cycle pulse in the final cycle of each instruction.
- `illegal`  out  1  high while in TRAP.

## Operation
- Outputs are Moore-decoded from the state. Two exceptions are Mealy:
  - `PC_write` in BRANCH depends on `Zero`.
  - ALU decode in EXECR and EXECI depends on `funct3`/`funct7`.
- Unlisted outputs default to 0.
- FETCH, held for 1+IMEM_WAIT cycles by a wait counter:
  - Every cycle: `adr_src`=0.
  - Last cycle only: `IR_write`=1, `alu_src_a`=0, `alu_src_b`=2, ADD, `result_src`=2, `PC_write`=1.
  - Next state: DECODE.
- DECODE: `alu_src_a`=1, `alu_src_b`=1, ADD, `imm_src`=B/J by opcode. This latches old_PC+imm into ALU_out. Dispatch by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - 0010111 → AUIPC
  - anything else → TRAP
- MEMADR: `alu_src_a`=2, `alu_src_b`=1, ADD, `imm_src`=I for loads or S for stores. Loads go to MEMREAD; stores go to MEMWRITE.
- MEMREAD (1+DMEM_WAIT cycles, counter): `adr_src`=1, `result_src`=0. Then MEMWB.
- MEMWB: `result_src`=1, `reg_write`=1, `retired`=1. Then FETCH.
- MEMWRITE: `adr_src`=1, `result_src`=0, `mem_write`=1, `retired`=1. Then FETCH.
- EXECR: `alu_src_a`=2, `alu_src_b`=0. Op from `funct3`; `funct7[5]` selects SUB for 000 and SRA for 101. Then ALUWB.
- EXECI: `alu_src_a`=2, `alu_src_b`=1, `imm_src`=I. `funct7[5]` is honoured only for funct3=101 (SRAI); funct3=000 is always ADD. Then ALUWB.
- ALUWB: `result_src`=0, `reg_write`=1, `retired`=1. Then FETCH.
- BRANCH: `alu_src_a`=2, `alu_src_b`=0, `result_src`=0, `retired`=1. Then FETCH. ALU op and taken condition by `funct3`:
  - beq: SUB, taken = `Zero`
  - bne: SUB, taken = !`Zero`
  - blt: SLT, taken = !`Zero`
  - bge: SLT, taken = `Zero`
  - bltu: SLTU, taken = !`Zero`
  - bgeu: SLTU, taken = `Zero`
  - funct3 010 or 011 → TRAP
- JAL: `alu_src_a`=1, `alu_src_b`=2, ADD, `result_src`=0, `PC_write`=1. Then ALUWB, which writes old_PC+4 to rd.
- JALR: `alu_src_a`=2, `alu_src_b`=1, `imm_src`=I, ADD. Then JALR_PC.
- JALR_PC: `result_src`=0, `PC_write`=1, `alu_src_a`=1, `alu_src_b`=2, ADD. Then ALUWB.
- LUI: `alu_src_b`=1, `imm_src`=U, PASSB. Then ALUWB.
- AUIPC: `alu_src_a`=1, `alu_src_b`=1, `imm_src`=U, ADD. Then ALUWB.
- TRAP: `illegal`=1. All enables are 0. The FSM stays in TRAP until reset.

## Timing
- `reset` low at a rising edge: state ← FETCH, wait counters ← 0.
- While `reset` is low, all write enables and `retired` are forced to 0 combinationally, and `illegal`=0.
- Reset asserted mid-instruction aborts it; no partial register write or PC update happens in the reset cycle.
- Cycles per instruction at defaults:
  - R-type, I-type, LUI, AUIPC: 5
  - store: 5
  - branch: 4
  - load: 7
  - JAL: 5
  - JALR: 6
- Wait counters are log2-sized, clear on entering their state, and never wrap while in use. With a parameter at 0, the state lasts exactly 1 cycle.
- `retired` is high for exactly one cycle per instruction; it is never asserted in TRAP.

## Test plan
- Reset held low 3 cycles, then released → FETCH; `IR_write`=1 and `PC_write`=1 on the 2nd cycle after release; `illegal`=0.
- `add` (op 0110011, f3 000, f7 0100000 for the sub variant) → `alu_control`=0001 in EXECR; `reg_write`=1 in ALUWB; `retired` 5 cycles after fetch start.
- `lw` (op 0000011) → `adr_src`=1 for 2 cycles, then `result_src`=1 with `reg_write`=1; 7 cycles total. `sw` → `mem_write`=1 for exactly 1 cycle.
- `bne` with `Zero`=0 → `PC_write`=1 in BRANCH; `bne` with `Zero`=1 → `PC_write`=0 and the FSM returns to FETCH.
- `jalr` → PC written in JALR_PC; rd written in ALUWB with `result_src`=0; 6 cycles total.
- Opcode 1111111 → TRAP, `illegal`=1 held 10 cycles. `reset` pulsed low mid-`lw` (in MEMREAD) → FETCH next cycle with no `reg_write`.

Source files
------------

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - RV32I multicycle control FSM with memory wait states, retire pulse and illegal trap
module multicycle_control #(
    parameter int IMEM_WAIT = 1,
    parameter int DMEM_WAIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op_code,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       Zero,
    output logic       adr_src,
    output logic       mem_write,
    output logic       IR_write,
    output logic       reg_write,
    output logic       PC_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] imm_src,
    output logic [3:0] alu_control,
    output logic       retired,
    output logic       illegal
);

    localparam int MAX_WAIT = (IMEM_WAIT > DMEM_WAIT) ? IMEM_WAIT : DMEM_WAIT;
    localparam int CW       = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] IMEM_LAST = CW'(IMEM_WAIT);
    localparam logic [CW-1:0] DMEM_LAST = CW'(DMEM_WAIT);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLL   = 4'b0101;
    localparam logic [3:0] ALU_SRL   = 4'b0110;
    localparam logic [3:0] ALU_SRA   = 4'b0111;
    localparam logic [3:0] ALU_SLT   = 4'b1000;
    localparam logic [3:0] ALU_SLTU  = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_JALR_PC,
        S_LUI,
        S_AUIPC,
        S_TRAP
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] wait_cnt;
    logic          fetch_last;
    logic          mem_last;

    logic          mem_write_raw;
    logic          ir_write_raw;
    logic          reg_write_raw;
    logic          pc_update;
    logic          branch_taken;
    logic          retired_raw;
    logic          illegal_raw;

    logic          alt_op;
    logic          unused_funct7;

    assign alt_op        = funct7[5];
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    assign fetch_last = (wait_cnt == IMEM_LAST);
    assign mem_last   = (wait_cnt == DMEM_LAST);

    // State register and wait counter; the counter clears whenever the state changes
    // and saturates at its terminal count so it never wraps while a wait state is held.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if ((state == S_FETCH && !fetch_last) ||
                         (state == S_MEMREAD && !mem_last)) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
        end
    end

    // Next-state dispatch and Moore/Mealy datapath control decode.
    always_comb begin
        state_next    = state;
        adr_src       = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        pc_update     = 1'b0;
        branch_taken  = 1'b0;
        result_src    = 2'd0;
        alu_src_a     = 2'd0;
        alu_src_b     = 2'd0;
        imm_src       = IMM_I;
        alu_control   = ALU_ADD;
        retired_raw   = 1'b0;
        illegal_raw   = 1'b0;

        case (state)
            S_FETCH: begin
                adr_src = 1'b0;
                if (fetch_last) begin
                    ir_write_raw = 1'b1;
                    alu_src_a    = 2'd0;
                    alu_src_b    = 2'd2;
                    alu_control  = ALU_ADD;
                    result_src   = 2'd2;
                    pc_update    = 1'b1;
                    state_next   = S_DECODE;
                end
            end

            S_DECODE: begin
                // Speculative branch/jump target: old_PC + imm lands in ALU_out.
                alu_src_a   = 2'd1;
                alu_src_b   = 2'd1;
                alu_control = ALU_ADD;
                imm_src     = (op_code == OP_JAL) ? IMM_J : IMM_B;
                case (op_code)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_R:              state_next = S_EXECR;
                    OP_I:              state_next = S_EXECI;
                    // Branch funct3 010/011 are unassigned; trap before anything retires.
                    OP_BRANCH:         state_next = (funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR;
                    OP_LUI:            state_next = S_LUI;
                    OP_AUIPC:          state_next = S_AUIPC;
                    default:           state_next = S_TRAP;
                endcase
            end

            S_MEMADR: begin
                alu_src_a   = 2'd2;
                alu_src_b   = 2'd1;
                alu_control = ALU_ADD;
                if (op_code == OP_STORE) begin
                    imm_src    = IMM_S;
                    state_next = S_MEMWRITE;
                end else begin
                    imm_src    = IMM_I;
                    state_next = S_MEMREAD;
                end
            end

            S_MEMREAD: begin
                adr_src    = 1'b1;
                result_src = 2'd0;
                if (mem_last) begin
                    state_next = S_MEMWB;
                end
            end

            S_MEMWB: begin
                result_src    = 2'd1;
                reg_write_raw = 1'b1;
                retired_raw   = 1'b1;
                state_next    = S_FETCH;
            end

            S_MEMWRITE: begin
                adr_src       = 1'b1;
                result_src    = 2'd0;
                mem_write_raw = 1'b1;
                retired_raw   = 1'b1;
                state_next    = S_FETCH;
            end

            S_EXECR: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd0;
                case (funct3)
                    3'b000:  alu_control = alt_op ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_SLTU;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = alt_op ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    default: alu_control = ALU_AND;
                endcase
                state_next = S_ALUWB;
            end

            S_EXECI: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                imm_src   = IMM_I;
                // No SUBI exists: funct3 000 is ADDI even when imm[10] is set.
                case (funct3)
                    3'b000:  alu_control = ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_SLTU;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = alt_op ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    default: alu_control = ALU_AND;
                endcase
                state_next = S_ALUWB;
            end

            S_ALUWB: begin
                result_src    = 2'd0;
                reg_write_raw = 1'b1;
                retired_raw   = 1'b1;
                state_next    = S_FETCH;
            end

            S_BRANCH: begin
                alu_src_a   = 2'd2;
                alu_src_b   = 2'd0;
                result_src  = 2'd0;
                retired_raw = 1'b1;
                // SLT/SLTU yield 1 (Zero low) when rs1 < rs2.
                case (funct3)
                    3'b000: begin alu_control = ALU_SUB;  branch_taken = Zero;  end
                    3'b001: begin alu_control = ALU_SUB;  branch_taken = !Zero; end
                    3'b100: begin alu_control = ALU_SLT;  branch_taken = !Zero; end
                    3'b101: begin alu_control = ALU_SLT;  branch_taken = Zero;  end
                    3'b110: begin alu_control = ALU_SLTU; branch_taken = !Zero; end
                    3'b111: begin alu_control = ALU_SLTU; branch_taken = Zero;  end
                    default: begin alu_control = ALU_SUB; branch_taken = 1'b0;  end
                endcase
                state_next = S_FETCH;
            end

            S_JAL: begin
                // PC takes the target latched in DECODE; ALU computes old_PC + 4 for rd.
                alu_src_a   = 2'd1;
                alu_src_b   = 2'd2;
                alu_control = ALU_ADD;
                result_src  = 2'd0;
                pc_update   = 1'b1;
                state_next  = S_ALUWB;
            end

            S_JALR: begin
                alu_src_a   = 2'd2;
                alu_src_b   = 2'd1;
                imm_src     = IMM_I;
                alu_control = ALU_ADD;
                state_next  = S_JALR_PC;
            end

            S_JALR_PC: begin
                result_src  = 2'd0;
                pc_update   = 1'b1;
                alu_src_a   = 2'd1;
                alu_src_b   = 2'd2;
                alu_control = ALU_ADD;
                state_next  = S_ALUWB;
            end

            S_LUI: begin
                alu_src_b   = 2'd1;
                imm_src     = IMM_U;
                alu_control = ALU_PASSB;
                state_next  = S_ALUWB;
            end

            S_AUIPC: begin
                alu_src_a   = 2'd1;
                alu_src_b   = 2'd1;
                imm_src     = IMM_U;
                alu_control = ALU_ADD;
                state_next  = S_ALUWB;
            end

            default: begin
                illegal_raw = 1'b1;
                state_next  = S_TRAP;
            end
        endcase
    end

    // Reset masks every side effect so an aborted instruction leaves no partial update.
    assign mem_write = mem_write_raw & reset;
    assign IR_write  = ir_write_raw & reset;
    assign reg_write = reg_write_raw & reset;
    assign PC_write  = (pc_update | branch_taken) & reset;
    assign retired   = retired_raw & reset;
    assign illegal   = illegal_raw & reset;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control against a per-instruction cycle model
module tb_multicycle_control;

    localparam int IMEM_WAIT = 1;
    localparam int DMEM_WAIT = 1;
    localparam int TRAP_HOLD = 10;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic       adr_src;
        logic       mem_write;
        logic       IR_write;
        logic       reg_write;
        logic       PC_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] imm_src;
        logic [3:0] alu_control;
        logic       retired;
        logic       illegal;
    } outs_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op_code;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       Zero;
    logic       adr_src, mem_write, IR_write, reg_write, PC_write, retired, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] imm_src;
    logic [3:0] alu_control;

    int    n_cmp  = 0;
    int    n_fail = 0;
    outs_t exp_q[$];

    multicycle_control #(.IMEM_WAIT(IMEM_WAIT), .DMEM_WAIT(DMEM_WAIT)) dut (
        .clk(clk), .reset(reset), .op_code(op_code), .funct3(funct3), .funct7(funct7), .Zero(Zero),
        .adr_src(adr_src), .mem_write(mem_write), .IR_write(IR_write), .reg_write(reg_write),
        .PC_write(PC_write), .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_src(imm_src), .alu_control(alu_control), .retired(retired), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic outs_t observed();
        return {adr_src, mem_write, IR_write, reg_write, PC_write, result_src, alu_src_a,
                alu_src_b, imm_src, alu_control, retired, illegal};
    endfunction

    function automatic logic [3:0] exec_op(input logic [2:0] f3, input logic alt, input logic is_r);
        case (f3)
            3'd0: return (is_r && alt) ? 4'd1 : 4'd0;
            3'd1: return 4'd5;
            3'd2: return 4'd8;
            3'd3: return 4'd9;
            3'd4: return 4'd4;
            3'd5: return alt ? 4'd7 : 4'd6;
            3'd6: return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    // Expected output for every cycle of one instruction, starting at its first fetch cycle.
    task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic alt, input logic z);
        outs_t c;
        outs_t wb;
        exp_q.delete();
        wb = '0; wb.reg_write = 1; wb.retired = 1;
        for (int i = 0; i <= IMEM_WAIT; i++) begin
            c = '0;
            if (i == IMEM_WAIT) begin
                c.IR_write = 1; c.alu_src_b = 2; c.result_src = 2; c.PC_write = 1;
            end
            exp_q.push_back(c);
        end
        c = '0; c.alu_src_a = 1; c.alu_src_b = 1; c.imm_src = (op == OP_JAL) ? 3'd3 : 3'd2;
        exp_q.push_back(c);
        case (op)
            OP_LOAD: begin
                c = '0; c.alu_src_a = 2; c.alu_src_b = 1; exp_q.push_back(c);
                for (int i = 0; i <= DMEM_WAIT; i++) begin
                    c = '0; c.adr_src = 1; exp_q.push_back(c);
                end
                c = '0; c.result_src = 1; c.reg_write = 1; c.retired = 1; exp_q.push_back(c);
            end
            OP_STORE: begin
                c = '0; c.alu_src_a = 2; c.alu_src_b = 1; c.imm_src = 3'd1; exp_q.push_back(c);
                c = '0; c.adr_src = 1; c.mem_write = 1; c.retired = 1; exp_q.push_back(c);
            end
            OP_R, OP_I: begin
                c = '0; c.alu_src_a = 2; c.alu_src_b = (op == OP_I) ? 2'd1 : 2'd0;
                c.alu_control = exec_op(f3, alt, op == OP_R);
                exp_q.push_back(c);
                exp_q.push_back(wb);
            end
            OP_BRANCH: begin
                if (f3 == 3'd2 || f3 == 3'd3) begin
                    for (int i = 0; i < TRAP_HOLD; i++) begin
                        c = '0; c.illegal = 1; exp_q.push_back(c);
                    end
                end else begin
                    c = '0; c.alu_src_a = 2; c.retired = 1;
                    c.alu_control = (f3[2:1] == 2'b00) ? 4'd1 : (f3[1] ? 4'd9 : 4'd8);
                    case (f3)
                        3'd0, 3'd5, 3'd7: c.PC_write = z;
                        default:          c.PC_write = !z;
                    endcase
                    exp_q.push_back(c);
                end
            end
            OP_JAL: begin
                c = '0; c.alu_src_a = 1; c.alu_src_b = 2; c.PC_write = 1; exp_q.push_back(c);
                exp_q.push_back(wb);
            end
            OP_JALR: begin
                c = '0; c.alu_src_a = 2; c.alu_src_b = 1; exp_q.push_back(c);
                c = '0; c.alu_src_a = 1; c.alu_src_b = 2; c.PC_write = 1; exp_q.push_back(c);
                exp_q.push_back(wb);
            end
            OP_LUI: begin
                c = '0; c.alu_src_b = 1; c.imm_src = 3'd4; c.alu_control = 4'd10; exp_q.push_back(c);
                exp_q.push_back(wb);
            end
            OP_AUIPC: begin
                c = '0; c.alu_src_a = 1; c.alu_src_b = 1; c.imm_src = 3'd4; exp_q.push_back(c);
                exp_q.push_back(wb);
            end
            default: begin
                for (int i = 0; i < TRAP_HOLD; i++) begin
                    c = '0; c.illegal = 1; exp_q.push_back(c);
                end
            end
        endcase
    endtask

    task automatic check(input string tag, input outs_t got, input outs_t want);
        n_cmp++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic check_len(input string tag, input int got, input int want);
        n_cmp++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    // Entered just after a negedge in the instruction's first fetch cycle; leaves at a negedge.
    task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                             input logic alt, input logic z, input int limit);
        int n;
        op_code = op;
        funct3  = f3;
        funct7  = 7'($urandom);
        funct7[5] = alt;
        Zero    = z;
        build(op, f3, alt, z);
        n = (limit > 0 && limit < exp_q.size()) ? limit : exp_q.size();
        for (int i = 0; i < n; i++) begin
            #1;
            check($sformatf("%s cyc%0d", tag, i), observed(), exp_q[i]);
            @(negedge clk);
        end
    endtask

    // Pull reset low mid-cycle: side effects vanish at once, then FETCH is held for n cycles.
    task automatic do_reset(input string tag, input int n);
        reset = 1'b0;
        #1;
        check($sformatf("%s mask", tag),
              outs_t'({mem_write, IR_write, reg_write, PC_write, retired, illegal}), outs_t'(0));
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("%s hold%0d", tag, i), observed(), outs_t'(0));
        end
        reset = 1'b1;
    endtask

    initial begin
        logic [6:0] ops [9];
        logic [6:0] op;
        logic [2:0] f3;
        ops = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
        reset = 1'b0; op_code = '0; funct3 = '0; funct7 = '0; Zero = 1'b0;
        @(negedge clk);
        do_reset("por", 3);

        // Cycle counts per instruction class at the default wait settings.
        build(OP_R, 3'd0, 1'b0, 1'b0);      check_len("len_r", exp_q.size(), 5);
        build(OP_LOAD, 3'd2, 1'b0, 1'b0);   check_len("len_lw", exp_q.size(), 7);
        build(OP_BRANCH, 3'd1, 1'b0, 1'b0); check_len("len_br", exp_q.size(), 4);
        build(OP_JALR, 3'd0, 1'b0, 1'b0);   check_len("len_jalr", exp_q.size(), 6);

        run_instr("add", OP_R, 3'd0, 1'b0, 1'b0, 0);
        run_instr("sub", OP_R, 3'd0, 1'b1, 1'b0, 0);
        run_instr("addi_alt", OP_I, 3'd0, 1'b1, 1'b0, 0);
        run_instr("srai", OP_I, 3'd5, 1'b1, 1'b0, 0);
        run_instr("lw", OP_LOAD, 3'd2, 1'b0, 1'b0, 0);
        run_instr("sw", OP_STORE, 3'd2, 1'b0, 1'b0, 0);
        run_instr("bne_z0", OP_BRANCH, 3'd1, 1'b0, 1'b0, 0);
        run_instr("bne_z1", OP_BRANCH, 3'd1, 1'b0, 1'b1, 0);
        run_instr("bgeu_z1", OP_BRANCH, 3'd7, 1'b0, 1'b1, 0);
        run_instr("jal", OP_JAL, 3'd0, 1'b0, 1'b0, 0);
        run_instr("jalr", OP_JALR, 3'd0, 1'b0, 1'b0, 0);
        run_instr("lui", OP_LUI, 3'd3, 1'b0, 1'b0, 0);
        run_instr("auipc", OP_AUIPC, 3'd6, 1'b0, 1'b0, 0);

        run_instr("trap_op", 7'b1111111, 3'd0, 1'b0, 1'b0, 0);
        do_reset("trap_rst", 1);
        run_instr("trap_br", OP_BRANCH, 3'd2, 1'b0, 1'b0, 0);
        do_reset("trapbr_rst", 1);

        run_instr("lw_abort_rd", OP_LOAD, 3'd2, 1'b0, 1'b0, 5);
        do_reset("abort_memread", 1);
        run_instr("lw_abort_wb", OP_LOAD, 3'd2, 1'b0, 1'b0, 6);
        do_reset("abort_memwb", 1);
        run_instr("add_after", OP_R, 3'd4, 1'b0, 1'b0, 0);

        for (int k = 0; k < 60; k++) begin
            op = ops[$urandom_range(0, 8)];
            f3 = 3'($urandom);
            if (op == OP_BRANCH && f3[2:1] == 2'b01) f3 = {1'b1, f3[1:0]};
            if (k % 12 == 11) begin
                run_instr($sformatf("rnd%0d_abort", k), op, f3, 1'($urandom), 1'($urandom),
                          $urandom_range(1, 3));
                do_reset($sformatf("rnd%0d_rst", k), 1);
            end else begin
                run_instr($sformatf("rnd%0d", k), op, f3, 1'($urandom), 1'($urandom), 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
